dmem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single-port data memory (`dmem`) between the core's load/store port (m0) and a debug/program-loader port (m1). Each accepted request is latched and then executed in one dedicated memory cycle. Read data returns on a registered response one cycle later. It sits between the core/loader and the `dmem` instance and is the only driver of the memory's `we`/`a`/`wd` inputs.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core
// load/store port (m0) and the debug/loader port (m1).
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic          last;       // 0 = m0, 1 = m1: port that won the last tie
    logic          owner;      // port being served in ACCESS
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          sel;

    // On a tie the port that did not win the previous tie is chosen.
    always_comb begin
        sel = 1'b0;
        if (m0_req && m1_req) sel = ~last;
        else if (m1_req)      sel = 1'b1;
    end

    assign mem_a  = lat_addr;
    assign mem_wd = lat_wdata;
    assign mem_we = (state == ACCESS) && lat_we;
    assign busy   = (state == ACCESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m0_rvalid <= 1'b0;
                    m1_rvalid <= 1'b0;
                    if (m0_req || m1_req) begin
                        owner     <= sel;
                        lat_we    <= sel ? m1_we    : m0_we;
                        lat_addr  <= sel ? m1_addr  : m0_addr;
                        lat_wdata <= sel ? m1_wdata : m0_wdata;
                        m0_gnt    <= ~sel;
                        m1_gnt    <= sel;
                        if (m0_req && m1_req) last <= sel;
                        state     <= ACCESS;
                    end else begin
                        m0_gnt <= 1'b0;
                        m1_gnt <= 1'b0;
                    end
                end
                ACCESS: begin
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                    // Writes are acknowledged with rvalid too; rdata only moves on reads.
                    if (owner) begin
                        m1_rvalid <= 1'b1;
                        if (!lat_we) m1_rdata <= mem_rd;
                    end else begin
                        m0_rvalid <= 1'b1;
                        if (!lat_we) m0_rdata <= mem_rd;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        busy;

    logic [31:0] mem [16];
    int          n_chk = 0;
    int          n_pass = 0;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_a[3:0]] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gnt/rvalid pattern for both ports requesting continuously, one entry per edge
    logic [7:0] exp_g0 = 8'b0001_0001; // bit i = edge i+1
    logic [7:0] exp_g1 = 8'b0100_0100;
    logic [7:0] exp_v0 = 8'b0010_0010;
    logic [7:0] exp_v1 = 8'b1000_1000;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h11;
        mem[2] = 32'h22;

        // reset and idle
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ctrl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_we}), 0);
        end
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wd", mem_wd, 0);

        // m0 write 7 -> addr 0, then read it back
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 0; m0_wdata = 32'd7;
        tick();
        chk("wr_gnt", 32'({m0_gnt, m1_gnt, busy}), 32'b101);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_a", mem_a, 0);
        chk("wr_mem_wd", mem_wd, 7);
        m0_we = 1'b0;
        tick();
        chk("wr_rvalid", 32'({m0_rvalid, m0_gnt, busy, mem_we}), 32'b1000);
        chk("wr_mem0", mem[0], 7);
        tick();
        chk("rd_gnt", 32'({m0_gnt, mem_we}), 32'b10);
        tick();
        chk("rd_rvalid", 32'(m0_rvalid), 1);
        chk("rd_rdata", m0_rdata, 7);

        // contention: both read continuously
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 2;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr_gnt_%0d", i), 32'({m0_gnt, m1_gnt}), 32'({exp_g0[i], exp_g1[i]}));
            chk($sformatf("rr_rv_%0d", i), 32'({m0_rvalid, m1_rvalid}), 32'({exp_v0[i], exp_v1[i]}));
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_m0_rdata", m0_rdata, 32'h11);
        chk("rr_m1_rdata", m1_rdata, 32'h22);

        // m1 write 25 -> addr 4; m0 requests during ACCESS
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4; m1_wdata = 32'd25;
        tick();
        chk("m1wr_gnt", 32'({m0_gnt, m1_gnt}), 32'b01);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 2;
        tick();
        chk("m1wr_rvalid", 32'({m0_gnt, m1_rvalid}), 32'b01);
        chk("m1wr_mem4", mem[4], 25);
        chk("m1wr_m0_rdata", m0_rdata, 32'h11);
        chk("m1wr_m1_rdata", m1_rdata, 32'h22);
        tick();
        chk("m0_late_gnt", 32'(m0_gnt), 1);
        m0_req = 1'b0;
        tick();
        chk("m0_late_rdata", m0_rdata, 32'h22);

        // tie with last=m1 goes to m0, leaving last=m0
        m0_req = 1'b1; m0_addr = 1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 1;
        tick();
        chk("tie1_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // m0 write 0xDEAD -> addr 3 aborted by reset mid-ACCESS
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 3; m0_wdata = 32'hDEAD;
        tick();
        chk("ab_gnt", 32'({m0_gnt, busy, mem_we}), 32'b111);
        m0_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("ab_rst_ctrl", 32'({m0_gnt, busy, mem_we}), 0);
        #1 reset = 1'b0;
        tick();
        chk("ab_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
        chk("ab_mem3", mem[3], 0);
        chk("ab_m0_rdata", m0_rdata, 0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 1;
        m1_req = 1'b1; m1_addr = 2;
        tick();
        chk("ab_tie_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
